hazard_stall_unit: RTL
======================

Name: hazard_stall_unit

Overview:
- Load-use and branch-operand hazard detector for the 5-stage MIPS pipeline.
- Complements the forwarding unit: where forwarding cannot supply an operand in time, this block stalls PC and IF/ID and injects a bubble into ID/EX.
- Generates the IF/ID flush for taken branches and jumps resolved in ID.
- Keeps a saturating stall-cycle counter for the debug unit.

Parameters:
- NB_REG_ADDR, 5, register address width
- NB_CNT, 32, stall-cycle counter width

Ports:
- i_clock  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_valid  in  1  pipeline advance enable (debug step); low = whole pipeline frozen
- i_rs_id  in  NB_REG_ADDR  rs of instruction in ID
- i_rt_id  in  NB_REG_ADDR  rt of instruction in ID
- i_use_rs_id  in  1  ID instruction reads rs
- i_use_rt_id  in  1  ID instruction reads rt (R-type, store, branch)
- i_branch_id  in  1  ID holds beq/bne (operands compared in ID)
- i_jump_rs_id  in  1  ID holds jr/jalr
- i_taken_id  in  1  branch taken / jump resolved in ID this cycle
- i_rd_ex  in  NB_REG_ADDR  destination register in EX
- i_load_ex  in  1  EX holds a load
- i_we_ex  in  1  EX instruction writes a register
- i_rd_mem  in  NB_REG_ADDR  destination register in MEM
- i_load_mem  in  1  MEM holds a load
- o_pc_we  out  1  PC write enable
- o_ifid_we  out  1  IF/ID write enable
- o_idex_bubble  out  1  zero ID/EX control (insert NOP)
- o_ifid_flush  out  1  clear IF/ID on next edge
- o_stalling  out  1  FSM is in STALL state
- o_stall_cycles  out  NB_CNT  saturating count of stall cycles since reset

Behaviour:
- Matches:
  - match_ex(r) = use(r) & r==i_rd_ex & i_rd_ex!=0.
  - match_mem(r) = use(r) & r==i_rd_mem & i_rd_mem!=0.
  - r ranges over rs and rt.
  - Register 0 never causes a hazard.
- Operand consumer in ID: ctl = i_branch_id | i_jump_rs_id.
- Required stalls N, evaluated in IDLE only; the first matching rule wins:
  - ctl & i_load_ex & match_ex: N=2.
  - ctl & i_we_ex & ~i_load_ex & match_ex: N=1. The ALU result is not available until the end of EX.
  - ~ctl & i_load_ex & match_ex: N=1.
  - ctl & i_load_mem & match_mem: N=1.
  - Otherwise N=0.
- FSM states are IDLE and STALL. A 2-bit counter cnt holds the remaining stall cycles after the current one.
- IDLE, N=0: outputs pass (pc_we=1, ifid_we=1, bubble=0).
- IDLE, N>0:
  - stall=1 this same cycle, with no registered latency.
  - On a valid edge: if N==1, stay in IDLE (conditions re-evaluate next cycle with the producer advanced).
  - On a valid edge: if N==2, go to STALL with cnt=1.
- STALL:
  - stall=1 and the hazard logic is ignored.
  - On a valid edge: cnt decrements; go to IDLE when cnt reaches 0.
- Output equations:
  - stall = (IDLE & N>0) | STALL.
  - o_pc_we = i_valid & ~stall.
  - o_ifid_we = i_valid & ~stall.
  - o_idex_bubble = i_valid & stall.
- Flush:
  - o_ifid_flush = i_valid & i_taken_id & ~stall.
  - A taken branch whose operands are still hazarded does not flush until its stall cycles end.
  - Flush and a new stall can never coincide.
- o_stall_cycles increments by 1 on each valid edge where stall=1. It saturates at all-ones; there is no wrap.
- i_valid=0:
  - State, cnt and counter hold.
  - o_pc_we=0, o_ifid_we=0, o_idex_bubble=0, o_ifid_flush=0.
  - o_stalling still reflects the state.
- Reset, including mid-stall: state=IDLE, cnt=0, o_stall_cycles=0, o_stalling=0.
  - While i_reset=1, all control outputs are forced to reset values: pc_we=0, ifid_we=0, bubble=0, flush=0.
- Simultaneous EX and MEM matches on different operands: the highest-N rule applies.

Test Plan:
- lw $5 in EX (i_load_ex=1, i_rd_ex=5), add using rs=5 in ID -> exactly 1 cycle with pc_we=0, ifid_we=0, bubble=1. Next cycle (load now in MEM, non-branch) N=0 and pass. o_stall_cycles=1.
- lw $7 in EX, beq rs=7 in ID -> 2 consecutive stall cycles, o_stalling=1 in the second cycle only. With i_taken_id=1, o_ifid_flush is asserted only in the third cycle. o_stall_cycles=2.
- Load with i_rd_ex=0 and ID rs=0 -> no stall; add with rt=5 but i_use_rt_id=0 against lw $5 -> no stall.
- jr $31 in ID with an ALU write of $31 in EX (i_we_ex=1, i_load_ex=0) -> 1 stall cycle. Then no further stall, since the producer in MEM is not a load, and flush is asserted.
- Mid-STALL: i_valid=0 for 3 cycles -> state and counter frozen, all enables 0. Then i_valid=1 -> the remaining single stall cycle completes.
- i_reset pulsed in STALL -> IDLE and counter 0 next cycle. With NB_CNT=2 and 5 stall cycles, o_stall_cycles saturates at 3.

Source files
------------

// File: rtl/hazard_stall_if.sv
// hazard_stall_if
//   Bundles the hazard-detection inputs coming from the pipeline registers
//   and the stall/flush controls going back to them.
//   Handshake: i_valid is a pipeline advance enable. A clock edge with
//   i_valid=1 moves the pipeline (and this unit's state) forward. With
//   i_valid=0 everything holds and no enable, bubble or flush is issued.
//   There is no ready; the stall outputs are the back-pressure.
//   master : pipeline side (drives i_*, reads o_*)
//   slave  : hazard_stall_unit (reads i_*, drives o_*)
interface hazard_stall_if #(
  parameter int NB_REG_ADDR = 5,
  parameter int NB_CNT      = 32
);
  logic                   i_valid;
  logic [NB_REG_ADDR-1:0] i_rs_id;
  logic [NB_REG_ADDR-1:0] i_rt_id;
  logic                   i_use_rs_id;
  logic                   i_use_rt_id;
  logic                   i_branch_id;
  logic                   i_jump_rs_id;
  logic                   i_taken_id;
  logic [NB_REG_ADDR-1:0] i_rd_ex;
  logic                   i_load_ex;
  logic                   i_we_ex;
  logic [NB_REG_ADDR-1:0] i_rd_mem;
  logic                   i_load_mem;
  logic                   o_pc_we;
  logic                   o_ifid_we;
  logic                   o_idex_bubble;
  logic                   o_ifid_flush;
  logic                   o_stalling;
  logic [NB_CNT-1:0]      o_stall_cycles;

  modport master (
    output i_valid, i_rs_id, i_rt_id, i_use_rs_id, i_use_rt_id,
           i_branch_id, i_jump_rs_id, i_taken_id, i_rd_ex, i_load_ex,
           i_we_ex, i_rd_mem, i_load_mem,
    input  o_pc_we, o_ifid_we, o_idex_bubble, o_ifid_flush, o_stalling,
           o_stall_cycles
  );

  modport slave (
    input  i_valid, i_rs_id, i_rt_id, i_use_rs_id, i_use_rt_id,
           i_branch_id, i_jump_rs_id, i_taken_id, i_rd_ex, i_load_ex,
           i_we_ex, i_rd_mem, i_load_mem,
    output o_pc_we, o_ifid_we, o_idex_bubble, o_ifid_flush, o_stalling,
           o_stall_cycles
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit
//   Load-use / branch-operand hazard detector for the 5-stage MIPS pipeline.
//   Stalls PC and IF/ID and bubbles ID/EX when forwarding cannot deliver an
//   operand in time, flushes IF/ID for taken branches/jumps resolved in ID,
//   and keeps a saturating stall-cycle counter for the debug unit.
//   Ports:
//     i_clock : clock
//     i_reset : synchronous, active-high reset
//     hz      : hazard_stall_if.slave (pipeline hazard inputs, stall/flush
//               outputs, o_stalling as FSM state debug, o_stall_cycles)
module hazard_stall_unit #(
  parameter int NB_REG_ADDR = 5,
  parameter int NB_CNT      = 32
) (
  input  logic           i_clock,
  input  logic           i_reset,
  hazard_stall_if.slave  hz
);

  typedef enum logic {IDLE = 1'b0, STALL = 1'b1} state_t;

  localparam logic [NB_REG_ADDR-1:0] REG_ZERO = '0;

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [NB_CNT-1:0] stall_cnt_q;

  logic       ctl;
  logic       match_ex, match_mem;
  logic [1:0] n_req;
  logic       stall;

  // Register 0 is hardwired, so a producer targeting it never hazards.
  assign match_ex =
      (hz.i_rd_ex != REG_ZERO) &&
      ((hz.i_use_rs_id && (hz.i_rs_id == hz.i_rd_ex)) ||
       (hz.i_use_rt_id && (hz.i_rt_id == hz.i_rd_ex)));

  assign match_mem =
      (hz.i_rd_mem != REG_ZERO) &&
      ((hz.i_use_rs_id && (hz.i_rs_id == hz.i_rd_mem)) ||
       (hz.i_use_rt_id && (hz.i_rt_id == hz.i_rd_mem)));

  // Branches and jr/jalr consume operands in ID, one stage earlier than ALU ops.
  assign ctl = hz.i_branch_id | hz.i_jump_rs_id;

  // Priority order puts the only N=2 rule first, so when EX and MEM both
  // match the larger requirement wins.
  always_comb begin
    n_req = 2'd0;
    if (ctl && hz.i_load_ex && match_ex)
      n_req = 2'd2;
    else if (ctl && hz.i_we_ex && !hz.i_load_ex && match_ex)
      n_req = 2'd1;
    else if (!ctl && hz.i_load_ex && match_ex)
      n_req = 2'd1;
    else if (ctl && hz.i_load_mem && match_mem)
      n_req = 2'd1;
  end

  // cnt_q holds the stall cycles still owed after the current one. An N=1
  // stall stays in IDLE: next cycle the producer has advanced and the match
  // logic decides afresh.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        stall = (n_req != 2'd0);
        if (hz.i_valid && (n_req == 2'd2)) begin
          state_d = STALL;
          cnt_d   = 2'd1;
        end
      end
      STALL: begin
        stall = 1'b1;
        if (hz.i_valid) begin
          cnt_d = cnt_q - 2'd1;
          if (cnt_q <= 2'd1) begin
            state_d = IDLE;
            cnt_d   = 2'd0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (hz.i_valid && stall && !(&stall_cnt_q))
        stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  // A stalled taken branch has not finished comparing operands, so the flush
  // waits until the stall clears; flush and stall are mutually exclusive.
  assign hz.o_pc_we        = !i_reset && hz.i_valid && !stall;
  assign hz.o_ifid_we      = !i_reset && hz.i_valid && !stall;
  assign hz.o_idex_bubble  = !i_reset && hz.i_valid && stall;
  assign hz.o_ifid_flush   = !i_reset && hz.i_valid && hz.i_taken_id && !stall;
  assign hz.o_stalling     = !i_reset && (state_q == STALL);
  assign hz.o_stall_cycles = stall_cnt_q;

endmodule
